// File: rtl/baud_gen_frac.sv
// -----------------------------------------------------------------------------
// baud_gen_frac
//
// Fractional baud-rate generator. It produces an oversample tick (tick_os)
// whose average period is div_int + div_frac/2^FRAC_W sys_clk cycles. A
// fractional accumulator decides whether each period is div_int or div_int+1
// cycles long. Every OVERSAMPLE ticks it also produces a bit-rate tick
// (tick_bit), and it derives a bit-rate square wave (bclk) and a
// tick-rate toggle (bclkx8).
//
// The divisor is double buffered. A load strobe captures the selected
// divisor (a preset or div_int/div_frac) into a shadow register. The shadow
// becomes active at the next counter wrap, so a period is never cut short or
// stretched by a divisor change.
//
// Ports
//   sys_clk    in   system clock; all state is updated on its rising edge
//   rst        in   asynchronous active-high reset
//   en         in   count enable; while low all counters hold
//   use_preset in   1: use the preset selected by sel_baud, 0: div_int/div_frac
//   sel_baud   in   preset index (00=115200 01=38400 10=9600 11=4800)
//   div_int    in   custom integer divisor (sys_clk cycles per tick)
//   div_frac   in   custom fractional divisor (units of 1/2^FRAC_W cycle)
//   load       in   strobe: capture the selected divisor into the shadow
//   sync_clr   in   strobe: realign phase (counter, os_cnt, acc to zero)
//   tick_os    out  one-cycle pulse at the oversample rate
//   tick_bit   out  one-cycle pulse at the bit rate
//   bclk       out  bit-rate square wave, high for the first half of a bit
//   bclkx8     out  level toggling on every tick_os
//   div_err    out  sticky: a captured integer divisor was below 2
// -----------------------------------------------------------------------------
module baud_gen_frac #(
  parameter int unsigned OVERSAMPLE   = 8,
  parameter int unsigned DIV_W        = 16,
  parameter int unsigned FRAC_W       = 4,
  parameter int unsigned PRESET_INT0  = 108,
  parameter int unsigned PRESET_FRAC0 = 8,
  parameter int unsigned PRESET_INT1  = 325,
  parameter int unsigned PRESET_FRAC1 = 8,
  parameter int unsigned PRESET_INT2  = 1302,
  parameter int unsigned PRESET_FRAC2 = 1,
  parameter int unsigned PRESET_INT3  = 2604,
  parameter int unsigned PRESET_FRAC3 = 3
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              en,
  input  logic              use_preset,
  input  logic [1:0]        sel_baud,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              load,
  input  logic              sync_clr,
  output logic              tick_os,
  output logic              tick_bit,
  output logic              bclk,
  output logic              bclkx8,
  output logic              div_err
);

  localparam int unsigned     OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2);

  if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
    $error("baud_gen_frac: OVERSAMPLE must be an even number >= 4");
  end

  typedef struct packed {
    logic [DIV_W-1:0]  whole;
    logic [FRAC_W-1:0] frac;
  } divisor_t;

  localparam divisor_t RESET_DIV = {DIV_W'(PRESET_INT3), FRAC_W'(PRESET_FRAC3)};

  // ---------------------------------------------------------------------------
  // Divisor selection and clamping
  // ---------------------------------------------------------------------------
  divisor_t sel_div;   // divisor selected by use_preset / sel_baud
  divisor_t cap_div;   // selected divisor after clamping, as it is captured
  logic     clamp;     // selected integer divisor is 0 or 1

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    sel_div = {div_int, div_frac};
    if (use_preset) begin
      case (sel_baud)
        2'd0:    sel_div = {DIV_W'(PRESET_INT0), FRAC_W'(PRESET_FRAC0)};
        2'd1:    sel_div = {DIV_W'(PRESET_INT1), FRAC_W'(PRESET_FRAC1)};
        2'd2:    sel_div = {DIV_W'(PRESET_INT2), FRAC_W'(PRESET_FRAC2)};
        default: sel_div = {DIV_W'(PRESET_INT3), FRAC_W'(PRESET_FRAC3)};
      endcase
    end
    // A period shorter than 2 cycles cannot produce a one-cycle pulse followed
    // by a low cycle, so such divisors are raised to 2.
    clamp   = (sel_div.whole < DIV_W'(2));
    cap_div = sel_div;
    if (clamp) begin
      cap_div.whole = DIV_W'(2);
    end
  end

  // ---------------------------------------------------------------------------
  // Period counter, fractional accumulator, oversample counter
  // ---------------------------------------------------------------------------
  divisor_t          act_div;   // divisor governing the running period
  divisor_t          sh_div;    // shadow divisor waiting for the next wrap
  logic              sh_pend;   // shadow holds a divisor not yet active
  logic              sh_now;    // shadow was loaded while disabled: apply next cycle

  logic [DIV_W-1:0]  cnt;       // cycle position within the current period
  logic [DIV_W-1:0]  last_cnt;  // final count of the current period
  logic [FRAC_W-1:0] acc;       // fractional phase accumulator
  logic              carry_q;   // current period is stretched by one cycle
  logic [FRAC_W:0]   acc_sum;   // accumulator update including carry out
  logic [OS_W-1:0]   os_cnt;    // tick index within the bit
  logic              fire;      // this edge ends the period and emits a tick

  // act_div.whole is never below 2, so subtracting one cannot underflow.
  assign last_cnt = act_div.whole - DIV_W'(1) + DIV_W'(carry_q);
  // The >= compare also wraps safely if a divisor applied while disabled is
  // shorter than the count already reached.
  assign fire     = en && !sync_clr && (cnt >= last_cnt);
  assign acc_sum  = {1'b0, acc} + {1'b0, act_div.frac};

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      carry_q  <= 1'b0;
      os_cnt   <= '0;
      tick_os  <= 1'b0;
      tick_bit <= 1'b0;
      bclkx8   <= 1'b0;
    end else begin
      // NOTE: registers are updated with non-blocking assignments so every
      // right-hand side reads the value from before this clock edge.
      // The pulses are registered copies of fire. They drop on the next edge
      // even if en has gone low, so a pending pulse lasts exactly one cycle.
      tick_os  <= fire;
      tick_bit <= fire && (os_cnt == OS_LAST);
      if (sync_clr) begin
        cnt     <= '0;
        acc     <= '0;
        carry_q <= 1'b0;
        os_cnt  <= '0;
      end else if (fire) begin
        cnt     <= '0;
        acc     <= acc_sum[FRAC_W-1:0];
        carry_q <= acc_sum[FRAC_W];
        os_cnt  <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
        bclkx8  <= ~bclkx8;
      end else if (en) begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow / active divisor and error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      act_div <= RESET_DIV;
      sh_div  <= RESET_DIV;
      sh_pend <= 1'b0;
      sh_now  <= 1'b0;
      div_err <= 1'b0;
    end else begin
      if (load && clamp) begin
        div_err <= 1'b1;
      end
      if (load) begin
        sh_div <= cap_div;
      end
      if (load && sync_clr) begin
        // The phase restarts this edge, so the new divisor can take over
        // without splitting a period.
        act_div <= cap_div;
        sh_pend <= 1'b0;
        sh_now  <= 1'b0;
      end else begin
        if (sh_pend && (fire || sh_now)) begin
          act_div <= sh_div;
          sh_pend <= 1'b0;
          sh_now  <= 1'b0;
        end
        // A fresh load overrides the clear above. A shadow captured on the
        // same edge as a wrap still waits for the following wrap.
        if (load) begin
          sh_pend <= 1'b1;
          sh_now  <= !en;
        end
      end
    end
  end

  assign bclk = (os_cnt < OS_HALF);

endmodule

// File: tb/tb_baud_gen_frac.sv
// -----------------------------------------------------------------------------
// tb_baud_gen_frac
//
// Directed testbench for baud_gen_frac with default parameters. It drives
// inputs and samples outputs on the falling edge of sys_clk. Expected
// periods are hand-computed from the divisor arithmetic.
// -----------------------------------------------------------------------------
module tb_baud_gen_frac;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        en;
  logic        use_preset;
  logic [1:0]  sel_baud;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        load;
  logic        sync_clr;
  logic        tick_os;
  logic        tick_bit;
  logic        bclk;
  logic        bclkx8;
  logic        div_err;

  int tests = 0;
  int fails = 0;

  baud_gen_frac dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .en         (en),
    .use_preset (use_preset),
    .sel_baud   (sel_baud),
    .div_int    (div_int),
    .div_frac   (div_frac),
    .load       (load),
    .sync_clr   (sync_clr),
    .tick_os    (tick_os),
    .tick_bit   (tick_bit),
    .bclk       (bclk),
    .bclkx8     (bclkx8),
    .div_err    (div_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Cycles until the next tick_os, counted in falling edges.
  task automatic wait_tick(output int n, input int limit);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!tick_os && n < limit);
    if (!tick_os) check("tick_os_timeout", tick_os, 1);
  endtask

  // Cycles and tick_os pulses until the next tick_bit.
  task automatic wait_bit(output int n, output int ticks, input int limit);
    n = 0;
    ticks = 0;
    do begin
      @(negedge sys_clk);
      n++;
      if (tick_os) ticks++;
    end while (!tick_bit && n < limit);
    if (!tick_bit) check("tick_bit_timeout", tick_bit, 1);
  endtask

  // Measures k consecutive tick periods: their sum, how many equal hi_p, and
  // how many fall outside lo_p..hi_p.
  task automatic measure(input int k, input int lo_p, input int hi_p,
                         output int sum, output int n_hi, output int n_bad);
    int p;
    sum = 0;
    n_hi = 0;
    n_bad = 0;
    for (int i = 0; i < k; i++) begin
      wait_tick(p, hi_p + 10);
      sum += p;
      if (p == hi_p) n_hi++;
      if (p < lo_p || p > hi_p) n_bad++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    load = 1'b0;
    sync_clr = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic load_div(input int i, input int f, input logic p, input logic [1:0] s);
    div_int    = 16'(i);
    div_frac   = 4'(f);
    use_preset = p;
    sel_baud   = s;
    load       = 1'b1;
    @(negedge sys_clk);
    load       = 1'b0;
  endtask

  initial begin
    int n, t, sum, n_hi, n_bad, first, h, l;
    logic x;

    rst = 1'b1; en = 1'b0; use_preset = 1'b0; sel_baud = 2'd0;
    div_int = '0; div_frac = '0; load = 1'b0; sync_clr = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Reset state.
    check("rst_tick_os", tick_os, 0);
    check("rst_tick_bit", tick_bit, 0);
    check("rst_bclk", bclk, 1);
    check("rst_bclkx8", bclkx8, 0);
    check("rst_div_err", div_err, 0);

    // Reset divisor 2604 + 3/16: first tick after one full period, first bit
    // after 7*2604 + 2605 cycles (the 6th accumulation carries).
    rst = 1'b0;
    en  = 1'b1;
    n = 0;
    first = 0;
    do begin
      @(negedge sys_clk);
      n++;
      if (tick_os && first == 0) first = n;
    end while (!tick_bit && n < 25000);
    check("reset_first_tick", first, 2604);
    check("reset_first_bit", n, 20833);

    // Integer divisor 4: tick every 4, bit every 32, bclk 16 high / 16 low.
    do_reset();
    load_div(4, 0, 1'b0, 2'd0);
    @(negedge sys_clk);
    en = 1'b1;
    wait_tick(n, 100);
    check("div4_first_period", n, 4);
    wait_tick(n, 100);
    check("div4_period", n, 4);
    wait_bit(n, t, 100);
    check("div4_bclk_at_bit", bclk, 1);
    h = 0;
    while (bclk && h < 100) begin h++; @(negedge sys_clk); end
    l = 0;
    while (!bclk && l < 100) begin l++; @(negedge sys_clk); end
    check("div4_bclk_high", h, 16);
    check("div4_bclk_low", l, 16);
    check("div4_bit_period", tick_bit, 1);
    x = bclkx8;
    wait_tick(n, 100);
    check("div4_bclkx8_toggle", bclkx8, {31'd0, ~x});

    // 4 + 8/16: periods alternate 4/5, 16 ticks span 72 cycles.
    load_div(4, 8, 1'b0, 2'd0);
    measure(4, 4, 5, sum, n_hi, n_bad);
    measure(16, 4, 5, sum, n_hi, n_bad);
    check("frac_16_sum", sum, 72);
    check("frac_16_fives", n_hi, 8);
    check("frac_16_range", n_bad, 0);

    // Preset 115200: 108 + 8/16, 16 ticks span 1736 cycles.
    load_div(0, 0, 1'b1, 2'd0);
    measure(2, 4, 109, sum, n_hi, n_bad);
    measure(16, 108, 109, sum, n_hi, n_bad);
    check("preset0_16_sum", sum, 1736);
    check("preset0_16_109s", n_hi, 8);
    check("preset0_16_range", n_bad, 0);

    // Divisor 1 is clamped to 2 and sets the sticky error.
    do_reset();
    load_div(1, 0, 1'b0, 2'd0);
    check("clamp_div_err", div_err, 1);
    @(negedge sys_clk);
    en = 1'b1;
    wait_tick(n, 100);
    check("clamp_period_a", n, 2);
    wait_tick(n, 100);
    check("clamp_period_b", n, 2);
    load_div(5, 0, 1'b0, 2'd0);
    check("clamp_err_sticky", div_err, 1);
    wait_tick(n, 100);
    wait_tick(n, 100);
    check("after_clamp_period", n, 5);
    do_reset();
    check("div_err_cleared", div_err, 0);

    // sync_clr mid-bit with os_cnt = 5.
    load_div(4, 0, 1'b0, 2'd0);
    @(negedge sys_clk);
    en = 1'b1;
    wait_bit(n, t, 300);
    repeat (5) wait_tick(n, 100);
    @(negedge sys_clk);
    sync_clr = 1'b1;
    @(negedge sys_clk);
    sync_clr = 1'b0;
    check("sync_no_tick", tick_os, 0);
    check("sync_bclk_high", bclk, 1);
    wait_bit(n, t, 300);
    check("sync_bit_cycles", n, 32);
    check("sync_bit_ticks", t, 8);

    // sync_clr on the wrap edge suppresses that tick.
    repeat (3) @(negedge sys_clk);
    sync_clr = 1'b1;
    @(negedge sys_clk);
    sync_clr = 1'b0;
    check("sync_wrap_suppress", tick_os, 0);
    wait_tick(n, 100);
    check("sync_wrap_next", n, 4);
    wait_bit(n, t, 300);
    check("sync_wrap_bit", n + 4, 32);

    // sync_clr with load: new divisor active at once.
    @(negedge sys_clk);
    div_int = 16'd6;
    load = 1'b1;
    sync_clr = 1'b1;
    @(negedge sys_clk);
    load = 1'b0;
    sync_clr = 1'b0;
    wait_tick(n, 100);
    check("sync_load_period", n, 6);

    // A load mid-period keeps the running period; the new one follows.
    @(negedge sys_clk);
    load_div(3, 0, 1'b0, 2'd0);
    wait_tick(n, 100);
    check("load_keeps_period", n, 4);
    wait_tick(n, 100);
    check("load_next_period", n, 3);

    // en dropped while the tick is showing: one-cycle pulse, then hold.
    en = 1'b0;
    x = bclkx8;
    @(negedge sys_clk);
    check("en_drop_pulse_ends", tick_os, 0);
    t = 0;
    repeat (10) begin
      @(negedge sys_clk);
      if (tick_os) t++;
    end
    check("en_low_no_ticks", t, 0);
    check("en_low_bclkx8_hold", bclkx8, {31'd0, x});
    en = 1'b1;
    wait_tick(n, 100);
    check("en_resume_period", n, 3);

    // Reset in the cycle before a wrap: no pulse, reset divisor restored.
    @(negedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b1;
    @(negedge sys_clk);
    check("midrst_tick_os", tick_os, 0);
    check("midrst_tick_bit", tick_bit, 0);
    check("midrst_bclk", bclk, 1);
    check("midrst_bclkx8", bclkx8, 0);
    rst = 1'b0;
    wait_tick(n, 3000);
    check("midrst_first_tick", n, 2604);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/baud_gen_frac.md
BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
- REQ-001: Parameter OVERSAMPLE, default 8: oversample ticks per bit period; SHALL be an even number ≥ 4.
- REQ-002: Parameter DIV_W, default 16: width of the integer divisor.
- REQ-003: Parameter FRAC_W, default 4: width of the fractional divisor, in units of 1/2^FRAC_W cycle.
- REQ-004: Parameters PRESET_INT0..3 and PRESET_FRAC0..3, defaults 108/8, 325/8, 1302/1, 2604/3: divisors for 115200, 38400, 9600 and 4800 baud at a 100 MHz sys_clk with OVERSAMPLE=8.
- REQ-005: sys_clk  in  1  system clock; all state SHALL be clocked on its rising edge.
- REQ-006: rst  in  1  reset; asynchronous assertion, active-high.
- REQ-007: en  in  1  count enable; when low, all counters SHALL hold their values.
- REQ-008: use_preset  in  1  1 selects the preset divisor indexed by sel_baud; 0 selects div_int/div_frac.
- REQ-009: sel_baud  in  2  preset index: 00=115200, 01=38400, 10=9600, 11=4800.
- REQ-010: div_int  in  DIV_W  custom integer divisor, in sys_clk cycles per oversample tick.
- REQ-011: div_frac  in  FRAC_W  custom fractional divisor.
- REQ-012: load  in  1  single-cycle strobe that captures the selected divisor into the shadow register.
- REQ-013: sync_clr  in  1  single-cycle strobe that realigns the phase (used for RX start-bit alignment).
- REQ-014: tick_os  out  1  single-cycle pulse at the oversample rate.
- REQ-015: tick_bit  out  1  single-cycle pulse at the bit rate.
- REQ-016: bclk  out  1  square wave at the bit rate.
- REQ-017: bclkx8  out  1  level that toggles on every tick_os.
- REQ-018: div_err  out  1  sticky flag set when a captured integer divisor is below 2.

Function
- REQ-019: Effective tick period SHALL be div_int + div_frac/2^FRAC_W cycles.
- REQ-020: Fractional accumulator acc (FRAC_W bits) SHALL add the active div_frac on each tick_os.
- REQ-021: When that addition carries out, the next tick period SHALL be active div_int + 1 cycles; otherwise it SHALL be active div_int cycles.
- REQ-022: Cycle counter SHALL count 0 .. period-1 while en=1. tick_os SHALL be a registered pulse, high for exactly one cycle, in the cycle after the counter reaches period-1. The counter SHALL then wrap to 0.
- REQ-023: Oversample counter os_cnt (0..OVERSAMPLE-1) SHALL increment on each tick_os and wrap at OVERSAMPLE-1.
- REQ-024: tick_bit SHALL be asserted in the same cycle as the tick_os that wraps os_cnt.
- REQ-025: bclk SHALL be high while os_cnt < OVERSAMPLE/2 and low otherwise, giving a 50% duty cycle in tick units.
- REQ-026: On load, the divisor selected by use_preset and sel_baud SHALL be captured into the shadow register.
- REQ-027: The shadow divisor SHALL become active at the next counter wrap. If en=0 at capture, it SHALL become active on the next cycle.
- REQ-028: A load of 0 or 1 into the integer divisor SHALL be clamped to 2 and SHALL set div_err. Only rst SHALL clear div_err.
- REQ-029: sync_clr SHALL zero the cycle counter, os_cnt and acc on the next edge, and SHALL suppress tick_os and tick_bit in that cycle.
- REQ-030: sync_clr and load in the same cycle SHALL apply both: counters clear and the new divisor becomes active immediately.
- REQ-031: When en is deasserted while tick_os is pending, the pulse SHALL complete as one cycle and SHALL not repeat.
- REQ-032: The active divisor SHALL never change mid-period except via REQ-030.

Reset
- REQ-033: While rst=1: tick_os=0, tick_bit=0, bclk=1, bclkx8=0, div_err=0; all counters and acc = 0.
- REQ-034: While rst=1, the active and shadow divisors SHALL be loaded with PRESET_INT3/PRESET_FRAC3 (4800 baud).
- REQ-035: Reset asserted mid-period SHALL abort the period immediately, with no partial pulse.
- REQ-036: The first tick_os after rst release with en=1 SHALL occur after exactly one full period.

Verification
- REQ-037: div_int=4, div_frac=0, load, en=1 -> tick_os every 4 cycles; tick_bit every 32 cycles; bclk high for 16 cycles, low for 16.
- REQ-038: div_int=4, div_frac=8 -> tick_os periods alternate 4,5,4,5; 16 ticks span exactly 72 cycles.
- REQ-039: use_preset=1, sel_baud=00, load -> tick_os periods 108/109 alternating; 16 ticks span 1736 cycles.
- REQ-040: Reset with no load, en=1 -> first tick_os 2604 cycles after release; a 1-bit mismatch over 16 bits SHALL fail.
- REQ-041: sync_clr asserted mid-bit with os_cnt=5 -> no tick that cycle; next tick_bit exactly 8 ticks later; bclk high again.
- REQ-042: load with div_int=1 -> div_err=1; tick period 2 cycles; div_err stays 1 after a later valid load, clears only on rst.
